// File: rtl/fp_unpacker_pkg.sv
// Shared floating-point definitions: value classes and exponent bias helper.
package fp;

    typedef enum logic [2:0] {
        FP_ZERO    = 3'd0,
        FP_SUBNORM = 3'd1,
        FP_NORMAL  = 3'd2,
        FP_INF     = 3'd3,
        FP_QNAN    = 3'd4,
        FP_SNAN    = 3'd5
    } fp_class_t;

    // IEEE754 exponent bias for an nx-bit exponent field: 2**(nx-1) - 1.
    function automatic int unsigned EXP_OFFSET(input int unsigned nx);
        return (32'd1 << (nx - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_skid_buffer.sv
// Two-entry skid buffer with a registered input ready; keeps order under stalls.
module fp_skid_buffer #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         spare_valid;
    logic [W-1:0] spare_data;
    logic         spare_next;
    logic         in_fire;
    logic         main_free;

    assign in_fire   = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Occupancy of the spare entry after this edge; ready mirrors its inverse.
    always_comb begin
        spare_next = spare_valid;
        if (main_free) begin
            spare_next = 1'b0;
        end else if (in_fire) begin
            spare_next = 1'b1;
        end
    end

    // Main entry refills from the spare first so words never overtake each other.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            main_valid  <= 1'b0;
            main_data   <= '0;
            spare_valid <= 1'b0;
            spare_data  <= '0;
            in_ready    <= 1'b0;
        end else begin
            if (main_free) begin
                if (spare_valid) begin
                    main_valid <= 1'b1;
                    main_data  <= spare_data;
                end else begin
                    main_valid <= in_fire;
                    if (in_fire) begin
                        main_data <= in_data;
                    end
                end
            end else if (in_fire) begin
                spare_data <= in_data;
            end
            spare_valid <= spare_next;
            in_ready    <= !spare_next;
        end
    end

endmodule

// File: rtl/fp_unpacker.sv
// Streaming IEEE754 decoder: skid buffer feeding a registered decode stage.
`ifndef IEEE754
`define IEEE754(nx, nm) struct packed { logic sign; logic [(nx)-1:0] exp; logic [(nm)-1:0] mant; }
`endif

module fp_unpacker
    import fp::*;
#(
    parameter int unsigned NX = 8,
    parameter int unsigned NM = 23
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [NX+NM:0]    IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_SIGN,
    output logic [NX:0]       OUT_EXP,
    output logic [NM:0]       OUT_MANT,
    output fp_class_t         OUT_CLASS,
    output logic [15:0]       NAN_COUNT,
    input  logic              NAN_CLR
);

    localparam int unsigned W = 1 + NX + NM;
    localparam logic [NX:0] BIAS        = (NX+1)'(EXP_OFFSET(NX));
    localparam logic [NX:0] EXP_MIN     = (NX+1)'(1) - BIAS;
    localparam logic [NX:0] EXP_SPECIAL = {2'b01, {(NX-1){1'b0}}};

    typedef `IEEE754(NX, NM) word_t;

    logic         sk_valid;
    logic         sk_ready;
    logic [W-1:0] sk_data;
    word_t        word;
    logic         dec_sign;
    logic [NX:0]  dec_exp;
    logic [NM:0]  dec_mant;
    fp_class_t    dec_class;
    logic         nan_fire;

    fp_skid_buffer #(.W(W)) u_skid (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (IN_VALID),
        .in_ready  (IN_READY),
        .in_data   (IN_DATA),
        .out_valid (sk_valid),
        .out_ready (sk_ready),
        .out_data  (sk_data)
    );

    assign sk_ready = !OUT_VALID || OUT_READY;
    assign word     = word_t'(sk_data);

    // Classify the head word and derive unbiased exponent and hidden-bit mantissa.
    always_comb begin
        dec_sign  = word.sign;
        dec_mant  = {|word.exp, word.mant};
        dec_exp   = '0;
        dec_class = FP_ZERO;
        if (word.exp == '0) begin
            if (word.mant != '0) begin
                dec_class = FP_SUBNORM;
                dec_exp   = EXP_MIN;
            end
        end else if (&word.exp) begin
            dec_exp = EXP_SPECIAL;
            if (word.mant == '0) begin
                dec_class = FP_INF;
            end else if (word.mant[NM-1]) begin
                dec_class = FP_QNAN;
            end else begin
                dec_class = FP_SNAN;
            end
        end else begin
            dec_class = FP_NORMAL;
            dec_exp   = {1'b0, word.exp} - BIAS;
        end
    end

    // Output register: loads whenever it is empty or being drained this edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            OUT_SIGN  <= 1'b0;
            OUT_EXP   <= '0;
            OUT_MANT  <= '0;
            OUT_CLASS <= FP_ZERO;
        end else if (sk_ready) begin
            OUT_VALID <= sk_valid;
            if (sk_valid) begin
                OUT_SIGN  <= dec_sign;
                OUT_EXP   <= dec_exp;
                OUT_MANT  <= dec_mant;
                OUT_CLASS <= dec_class;
            end
        end
    end

    assign nan_fire = OUT_VALID && OUT_READY &&
                      (OUT_CLASS == FP_QNAN || OUT_CLASS == FP_SNAN);

    // Saturating count of NaN words delivered; clear wins over increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            NAN_COUNT <= '0;
        end else if (NAN_CLR) begin
            NAN_COUNT <= '0;
        end else if (nan_fire && !(&NAN_COUNT)) begin
            NAN_COUNT <= NAN_COUNT + 16'd1;
        end
    end

endmodule
